// File: rtl/lbist_seq_ctrl.sv
// LBIST sequencer: walks the seed ROM, runs SCAN_LEN-shift + capture patterns per seed,
// and checks the cumulative MISR signature per seed (mode 1) and after the final flush.
module lbist_seq_ctrl #(
  parameter int N_SEEDS    = 16,
  parameter int SEED_AW    = (N_SEEDS > 1) ? $clog2(N_SEEDS) : 1,
  parameter int PATTERNS   = 256,
  parameter int SCAN_LEN   = 64,
  parameter int MISR_W     = 64,
  parameter int RST_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        TEST,
  input  logic                        MODE,
  input  logic [MISR_W-1:0]           MISR_OUT,
  input  logic [N_SEEDS*MISR_W-1:0]   GOLDEN_SEED,
  input  logic [MISR_W-1:0]           GOLDEN_FINAL,
  output logic [SEED_AW-1:0]          SEED_ADDR,
  output logic                        TPG_LD,
  output logic                        TPG_MUX_en,
  output logic                        ODE_en,
  output logic                        SCAN_EN,
  output logic                        DUT_RESET,
  output logic                        LFSR_MISR_RESET,
  output logic                        END_TEST,
  output logic                        GO,
  output logic [SEED_AW-1:0]          FAIL_SEED,
  output logic                        FAIL_FINAL
);

  localparam int PAT_W   = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
  localparam int CNT_MAX = (SCAN_LEN > RST_CYCLES) ? SCAN_LEN : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [SEED_AW-1:0] LAST_SEED  = SEED_AW'(N_SEEDS - 1);
  localparam logic [PAT_W-1:0]   LAST_PAT   = PAT_W'(PATTERNS - 1);
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(SCAN_LEN - 1);
  localparam logic [CNT_W-1:0]   LAST_RST   = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RSTP, S_LOAD, S_SHIFT, S_CAPT, S_CMPS, S_FLUSH, S_CMPF, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [SEED_AW-1:0]   seed_q, seed_d;
  logic [PAT_W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 end_q, end_d;
  logic                 go_q, go_d;
  logic [SEED_AW-1:0]   fseed_q, fseed_d;
  logic                 ffin_q, ffin_d;
  logic [MISR_W-1:0]    golden_seed_sel;
  logic                 seed_last;

  assign golden_seed_sel = GOLDEN_SEED[int'(seed_q)*MISR_W +: MISR_W];
  assign seed_last       = (seed_q == LAST_SEED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      seed_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
      go_q    <= 1'b0;
      fseed_q <= '0;
      ffin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      go_q    <= go_d;
      fseed_q <= fseed_d;
      ffin_q  <= ffin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    go_d    = go_q;
    fseed_d = fseed_q;
    ffin_d  = ffin_q;
    case (state_q)
      S_IDLE: begin
        if (TEST) begin
          mode_d  = MODE;
          seed_d  = '0;
          pat_d   = '0;
          cnt_d   = '0;
          end_d   = 1'b0;
          go_d    = 1'b0;
          fseed_d = '0;
          ffin_d  = 1'b0;
          state_d = S_RSTP;
        end
      end
      S_RSTP: begin
        if (cnt_q == LAST_RST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT, S_FLUSH: begin
        if (cnt_q == LAST_SHIFT) begin
          cnt_d   = '0;
          state_d = (state_q == S_SHIFT) ? S_CAPT : S_CMPF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPT: begin
        if (pat_q != LAST_PAT) begin
          pat_d   = pat_q + PAT_W'(1);
          state_d = S_SHIFT;
        end else begin
          pat_d = '0;
          if (mode_q) begin
            state_d = S_CMPS;
          end else if (seed_last) begin
            state_d = S_FLUSH;
          end else begin
            seed_d  = seed_q + SEED_AW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_CMPS: begin
        if (MISR_OUT != golden_seed_sel) begin
          fseed_d = seed_q;
          go_d    = 1'b0;
          end_d   = 1'b1;
          state_d = S_DONE;
        end else if (seed_last) begin
          state_d = S_FLUSH;
        end else begin
          seed_d  = seed_q + SEED_AW'(1);
          state_d = S_LOAD;
        end
      end
      S_CMPF: begin
        if (MISR_OUT == GOLDEN_FINAL) begin
          go_d = 1'b1;
        end else begin
          go_d    = 1'b0;
          ffin_d  = 1'b1;
          fseed_d = LAST_SEED;
        end
        end_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!TEST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping TEST mid-run abandons the run without touching the fail indicators.
    if (!TEST && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_IDLE;
      end_d   = 1'b0;
      go_d    = 1'b0;
      fseed_d = fseed_q;
      ffin_d  = ffin_q;
    end
  end

  always_comb begin
    TPG_LD          = 1'b0;
    TPG_MUX_en      = 1'b0;
    ODE_en          = 1'b0;
    SCAN_EN         = 1'b0;
    DUT_RESET       = 1'b1;
    LFSR_MISR_RESET = 1'b0;
    case (state_q)
      S_RSTP: begin
        DUT_RESET       = 1'b0;
        LFSR_MISR_RESET = 1'b1;
      end
      S_LOAD: TPG_LD = 1'b1;
      S_SHIFT, S_FLUSH: begin
        SCAN_EN    = 1'b1;
        TPG_MUX_en = 1'b1;
        ODE_en     = 1'b1;
      end
      S_CAPT: TPG_MUX_en = 1'b1;
      S_DONE: DUT_RESET = 1'b0;
      default: ;
    endcase
  end

  assign SEED_ADDR  = seed_q;
  assign END_TEST   = end_q;
  assign GO         = go_q;
  assign FAIL_SEED  = fseed_q;
  assign FAIL_FINAL = ffin_q;

endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// Bench for lbist_seq_ctrl: a MISR stand-in plus a per-cycle expected control trace
// built from the seed/pattern/shift structure, and literal expectations per scenario.
module tb_lbist_seq_ctrl;
  localparam int N_SEEDS    = 2;
  localparam int PATTERNS   = 3;
  localparam int SCAN_LEN   = 4;
  localparam int MISR_W     = 16;
  localparam int RST_CYCLES = 2;
  localparam int SEED_AW    = 1;

  // Control vector order: {TPG_LD, TPG_MUX_en, ODE_en, SCAN_EN, DUT_RESET, LFSR_MISR_RESET, END_TEST}
  localparam logic [6:0] C_RSTP  = 7'b0000010;
  localparam logic [6:0] C_LOAD  = 7'b1000100;
  localparam logic [6:0] C_SHIFT = 7'b0111100;
  localparam logic [6:0] C_CAPT  = 7'b0100100;
  localparam logic [6:0] C_CMP   = 7'b0000100;
  localparam logic [6:0] C_IDLE  = 7'b0000100;
  localparam logic [6:0] C_DONE  = 7'b0000001;
  localparam logic [6:0] C_HELD  = 7'b0000101;
  localparam logic [15:0] MISR_INIT = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic TEST = 1'b0;
  logic MODE = 1'b0;
  logic [MISR_W-1:0] MISR_OUT;
  logic [N_SEEDS*MISR_W-1:0] GOLDEN_SEED = '0;
  logic [MISR_W-1:0] GOLDEN_FINAL = '0;
  logic [SEED_AW-1:0] SEED_ADDR, FAIL_SEED;
  logic TPG_LD, TPG_MUX_en, ODE_en, SCAN_EN, DUT_RESET, LFSR_MISR_RESET;
  logic END_TEST, GO, FAIL_FINAL;

  always #5 clk = ~clk;

  lbist_seq_ctrl #(
    .N_SEEDS(N_SEEDS), .PATTERNS(PATTERNS), .SCAN_LEN(SCAN_LEN),
    .MISR_W(MISR_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .TEST(TEST), .MODE(MODE), .MISR_OUT(MISR_OUT),
    .GOLDEN_SEED(GOLDEN_SEED), .GOLDEN_FINAL(GOLDEN_FINAL), .SEED_ADDR(SEED_ADDR),
    .TPG_LD(TPG_LD), .TPG_MUX_en(TPG_MUX_en), .ODE_en(ODE_en), .SCAN_EN(SCAN_EN),
    .DUT_RESET(DUT_RESET), .LFSR_MISR_RESET(LFSR_MISR_RESET), .END_TEST(END_TEST),
    .GO(GO), .FAIL_SEED(FAIL_SEED), .FAIL_FINAL(FAIL_FINAL)
  );

  function automatic logic [15:0] misr_step(input logic [15:0] x);
    return {x[14:0], 1'b0} ^ (x[15] ? 16'h1021 : 16'h0000) ^ 16'h0007;
  endfunction

  function automatic logic [15:0] golden_after(input int n);
    logic [15:0] x;
    x = MISR_INIT;
    for (int i = 0; i < n; i++) x = misr_step(x);
    return x;
  endfunction

  // MISR stand-in: compacts only on cycles the sequencer enables it.
  logic [15:0] misr_q = MISR_INIT;
  always @(posedge clk) begin
    if (LFSR_MISR_RESET) misr_q <= MISR_INIT;
    else if (ODE_en)     misr_q <= misr_step(misr_q);
  end
  assign MISR_OUT = misr_q;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {TPG_LD, TPG_MUX_en, ODE_en, SCAN_EN, DUT_RESET, LFSR_MISR_RESET, END_TEST};
  endfunction

  typedef struct packed {
    logic [6:0]         ctl;
    logic               chk_addr;
    logic [SEED_AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  bit   chk_on = 1'b0;
  int   tr_idx = 0;

  function automatic exp_t mk(input logic [6:0] c, input bit ca, input int a);
    exp_t e;
    e.ctl = c;
    e.chk_addr = ca;
    e.addr = SEED_AW'(a);
    return e;
  endfunction

  // Expected per-cycle controls from the edge leaving IDLE up to (not including) DONE.
  task automatic build_trace(input bit mode, input int stop_seed);
    exp_q.delete();
    for (int i = 0; i < RST_CYCLES; i++) exp_q.push_back(mk(C_RSTP, 1'b0, 0));
    for (int s = 0; s < N_SEEDS; s++) begin
      exp_q.push_back(mk(C_LOAD, 1'b1, s));
      for (int p = 0; p < PATTERNS; p++) begin
        for (int b = 0; b < SCAN_LEN; b++) exp_q.push_back(mk(C_SHIFT, 1'b0, 0));
        exp_q.push_back(mk(C_CAPT, 1'b0, 0));
      end
      if (mode) exp_q.push_back(mk(C_CMP, 1'b0, 0));
      if (s == stop_seed) return;
    end
    for (int b = 0; b < SCAN_LEN; b++) exp_q.push_back(mk(C_SHIFT, 1'b0, 0));
    exp_q.push_back(mk(C_CMP, 1'b0, 0));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_on && exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      check($sformatf("ctl@%0d", tr_idx), 32'(ctl_vec()), 32'(cur_e.ctl));
      if (cur_e.chk_addr)
        check($sformatf("seed_addr@%0d", tr_idx), 32'(SEED_ADDR), 32'(cur_e.addr));
      tr_idx++;
    end
  end

  task automatic set_goldens(input bit bad0, input bit badf);
    for (int i = 0; i < N_SEEDS; i++)
      GOLDEN_SEED[i*MISR_W +: MISR_W] = golden_after(PATTERNS*SCAN_LEN*(i+1));
    if (bad0) GOLDEN_SEED[0 +: MISR_W] = GOLDEN_SEED[0 +: MISR_W] ^ 16'h0100;
    GOLDEN_FINAL = golden_after(PATTERNS*SCAN_LEN*N_SEEDS + SCAN_LEN) ^ (badf ? 16'h8000 : 16'h0000);
  endtask

  task automatic start_run(input bit mode);
    @(negedge clk);
    MODE = mode;
    TEST = 1'b1;
    tr_idx = 0;
    chk_on = 1'b1;
  endtask

  // cyc counts edges after the one that leaves IDLE; flips MODE mid-run to prove it is latched.
  task automatic wait_end(output int cyc, output int n_ld, output int n_capt,
                          output int n_sen, output int n_cmp);
    bit done;
    cyc = -1; n_ld = 0; n_capt = 0; n_sen = 0; n_cmp = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) MODE = ~MODE;
      if (TPG_LD) n_ld++;
      if (TPG_MUX_en && !SCAN_EN) n_capt++;
      if (SCAN_EN) n_sen++;
      if (ctl_vec() == C_CMP) n_cmp++;
      if (END_TEST) done = 1'b1;
      else if (cyc >= 300) begin
        check("end_test_timeout", 32'(END_TEST), 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic run_full(input string tag, input bit mode, input bit bad0, input bit badf,
                          input int e_cyc, input bit e_go, input bit e_ff, input int e_fs,
                          input int e_ld, input int e_capt, input int e_sen, input int e_cmp);
    int cyc, nl, nc, ns, nm;
    set_goldens(bad0, badf);
    build_trace(mode, bad0 ? 0 : -1);
    start_run(mode);
    wait_end(cyc, nl, nc, ns, nm);
    chk_on = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
    check({tag, "_trace_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_ctl"}, 32'(ctl_vec()), 32'(C_DONE));
    check({tag, "_go"}, 32'(GO), 32'(e_go));
    check({tag, "_fail_final"}, 32'(FAIL_FINAL), 32'(e_ff));
    check({tag, "_fail_seed"}, 32'(FAIL_SEED), 32'(e_fs));
    check({tag, "_ld_pulses"}, 32'(nl), 32'(e_ld));
    check({tag, "_capt_cycles"}, 32'(nc), 32'(e_capt));
    check({tag, "_scan_en_cycles"}, 32'(ns), 32'(e_sen));
    check({tag, "_cmp_cycles"}, 32'(nm), 32'(e_cmp));
    TEST = 1'b0;
    @(negedge clk);
    check({tag, "_hold_ctl"}, 32'(ctl_vec()), 32'(C_HELD));
    check({tag, "_hold_flags"}, 32'({GO, FAIL_FINAL, FAIL_SEED}), 32'({e_go, e_ff, 1'(e_fs)}));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'(ctl_vec()), 32'(C_IDLE));
    check("rst_flags", 32'({GO, FAIL_FINAL, FAIL_SEED, SEED_ADDR}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctl", 32'(ctl_vec()), 32'(C_IDLE));

    //        tag      mode bad0 badf cyc go ff fs ld capt sen cmp
    run_full("m0_pass", 1'b0, 1'b0, 1'b0, 39, 1'b1, 1'b0, 0, 2, 6, 28, 1);
    run_full("m1_pass", 1'b1, 1'b0, 1'b0, 41, 1'b1, 1'b0, 0, 2, 6, 28, 3);
    run_full("m1_seed0_bad", 1'b1, 1'b1, 1'b0, 19, 1'b0, 1'b0, 0, 1, 3, 12, 1);
    run_full("m0_final_bad", 1'b0, 1'b0, 1'b1, 39, 1'b0, 1'b1, 1, 2, 6, 28, 1);

    // Drop TEST in the second shift cycle of seed 1.
    set_goldens(1'b0, 1'b0);
    build_trace(1'b0, -1);
    start_run(1'b0);
    repeat (21) @(negedge clk);
    check("drop_scan_en", 32'(SCAN_EN), 32'd1);
    check("drop_seed_addr", 32'(SEED_ADDR), 32'd1);
    TEST = 1'b0;
    chk_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("drop_idle_ctl", 32'(ctl_vec()), 32'(C_IDLE));
    check("drop_go", 32'(GO), 32'd0);
    run_full("rerun", 1'b0, 1'b0, 1'b0, 39, 1'b1, 1'b0, 0, 2, 6, 28, 1);

    // Synchronous reset in the second FLUSH cycle.
    build_trace(1'b0, -1);
    start_run(1'b0);
    repeat (36) @(negedge clk);
    check("flush_scan_en", 32'(SCAN_EN), 32'd1);
    check("flush_seed_addr", 32'(SEED_ADDR), 32'd1);
    rst = 1'b1;
    TEST = 1'b0;
    chk_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_ctl", 32'(ctl_vec()), 32'(C_IDLE));
    check("rst_mid_flags", 32'({GO, FAIL_FINAL, FAIL_SEED, SEED_ADDR}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(ctl_vec()), 32'(C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lbist_seq_ctrl.md
Name: lbist_seq_ctrl

Overview:
Parametrised LBIST sequencer; next generation of the single-signature LBIST controller. Walks N_SEEDS ROM seeds, applies PATTERNS scan patterns per seed (SCAN_LEN shift cycles plus one capture cycle each), and drives the LFSR, MISR, core reset and scan enable. Compares the MISR either once at the end, or after every seed with abort-on-first-mismatch. Sits beside the LFSR, MISR, seed ROM and core in the core wrapper.

Parameters:
N_SEEDS, 16, number of seeds walked (ROM depth used); must be >= 1.
SEED_AW, $clog2(N_SEEDS) (minimum 1), seed address width; derived, not overridden.
PATTERNS, 256, capture patterns per seed; must be >= 1.
SCAN_LEN, 64, shift cycles per pattern; must be >= 1.
MISR_W, 64, MISR/signature width.
RST_CYCLES, 4, cycles of core and LFSR/MISR reset before the first seed; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
TEST  in  1  level run request
MODE  in  1  0 = final compare only; 1 = per-seed plus final compare; sampled in IDLE only
MISR_OUT  in  MISR_W  current MISR signature
GOLDEN_SEED  in  N_SEEDS*MISR_W  slice i = expected cumulative signature after seed i (mode 1)
GOLDEN_FINAL  in  MISR_W  expected signature after flush
SEED_ADDR  out  SEED_AW  seed ROM address
TPG_LD  out  1  LFSR seed load
TPG_MUX_en  out  1  LFSR enable / core input mux select
ODE_en  out  1  MISR enable
SCAN_EN  out  1  scan shift enable
DUT_RESET  out  1  active-low core/RAM reset (0 = held in reset)
LFSR_MISR_RESET  out  1  active-high LFSR/MISR reset
END_TEST  out  1  run finished
GO  out  1  pass; valid only with END_TEST
FAIL_SEED  out  SEED_AW  index of the failing seed
FAIL_FINAL  out  1  failure was at the final compare

Behaviour:
- One clock domain (clk). Reset (rst) is synchronous and active-high.
- rst: state goes to IDLE. END_TEST, GO, FAIL_FINAL and all counters go to 0. FAIL_SEED goes to 0. The mode register goes to 0.
- Control outputs are Moore-decoded from the state register. Defaults: DUT_RESET=1; every other control output = 0.
- States and per-cycle outputs:
  - IDLE: all defaults.
    - TEST=1 → latch MODE, clear the seed and pattern counters, clear the result flags, go to RSTP.
  - RSTP: DUT_RESET=0, LFSR_MISR_RESET=1 for RST_CYCLES cycles, then go to LOAD.
  - LOAD: one cycle with TPG_LD=1 and SEED_ADDR=seed counter. Go to SHIFT.
  - SHIFT: SCAN_LEN cycles with SCAN_EN=1, TPG_MUX_en=1, ODE_en=1. Go to CAPT.
  - CAPT: one cycle with TPG_MUX_en=1. SCAN_EN=0 and ODE_en=0.
    - Not the last pattern → pattern counter +1, go to SHIFT.
    - Last pattern → clear the pattern counter. Mode 1 → go to CMPS. Mode 0 → next seed (see below).
  - CMPS (mode 1 only): one cycle, all enables 0.
    - MISR_OUT != GOLDEN_SEED slice[seed] → FAIL_SEED=seed, GO=0, go to DONE (abort).
    - Match → next seed.
  - Next seed: seed < N_SEEDS-1 → seed +1, go to LOAD. Otherwise go to FLUSH.
  - FLUSH: SCAN_LEN cycles with SCAN_EN=1, TPG_MUX_en=1, ODE_en=1. This unloads the last capture. Go to CMPF.
  - CMPF: one cycle, all enables 0.
    - MISR_OUT == GOLDEN_FINAL → GO=1.
    - Mismatch → GO=0, FAIL_FINAL=1, FAIL_SEED=N_SEEDS-1.
    - Go to DONE.
  - DONE: END_TEST=1. DUT_RESET=0 (core held in reset). GO, FAIL_SEED and FAIL_FINAL are held.
    - TEST=0 → go to IDLE. END_TEST, GO, FAIL_SEED and FAIL_FINAL hold through that IDLE cycle and clear on the next TEST=1.
- Seed boundaries: the first SHIFT of the next seed unloads the previous capture. The MISR is never reset between seeds, so golden values are cumulative.
- MISR is sampled only in CMPS/CMPF; ODE_en=0 there, so MISR_OUT is stable.
- TEST=0 in any state other than IDLE or DONE → go to IDLE next cycle (abort). END_TEST=0, GO=0.
- rst has priority over TEST at any point.
- Total cycles from the edge that leaves IDLE to DONE entry:
  - Mode 0: RST_CYCLES + N_SEEDS*(1 + PATTERNS*(SCAN_LEN+1)) + SCAN_LEN + 1.
  - Mode 1: add N_SEEDS (one CMPS per seed).
- Counter widths: sized for PATTERNS-1 and SCAN_LEN-1. No wrap occurs before the terminal compare.
- SEED_ADDR outside LOAD shows the current seed counter (don't-care for the ROM).

Test Plan:
- Parameters N_SEEDS=2, PATTERNS=3, SCAN_LEN=4, RST_CYCLES=2; MODE=0, TEST=1, GOLDEN_FINAL=MISR_OUT model → END_TEST=1 exactly 39 cycles after leaving IDLE. GO=1. Exactly 2 TPG_LD pulses (SEED_ADDR 0 then 1). 6 CAPT cycles. SCAN_EN high 28 cycles total.
- Same parameters, MODE=1, all goldens matching → END_TEST after 41 cycles, GO=1. CMPS occurs twice with ODE_en=0.
- MODE=1, GOLDEN_SEED slice 0 corrupted → abort after the first CMPS (cycle 19). GO=0, FAIL_SEED=0, FAIL_FINAL=0. No second TPG_LD.
- MODE=0, GOLDEN_FINAL corrupted → GO=0, FAIL_FINAL=1, FAIL_SEED=1.
- TEST dropped during seed 1 SHIFT → IDLE next cycle. DUT_RESET=1, END_TEST=0. A rerun with TEST=1 repeats the full 39-cycle sequence.
- rst pulse mid-FLUSH → IDLE next cycle. All outputs at reset values. LFSR_MISR_RESET=0, DUT_RESET=1.
